mmio_host_seq: RTL and testbench



---
 rtl/mmio_host_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_mmio_host_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_host_seq.sv
// mmio_host_seq: MMIO bus initiator that configures the coprocessor's
// register shadow and runs inference jobs (program, start, poll, read G).
//
// Request handshake: cfg_req/job_req are one-cycle requests that are
// accepted only while the sequencer is in IDLE; a request seen in any
// other cycle (busy=1, or the completion cycle carrying cfg_done/res_valid)
// is dropped and the source must retry. If both arrive together, cfg_req
// wins. Completion is signalled by a one-cycle cfg_done or res_valid pulse,
// and busy is low on that cycle.
module mmio_host_seq #(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_req,
    input  logic [191:0] cfg_thr,
    input  logic         job_req,
    input  logic [7:0]   job_T,
    input  logic [7:0]   job_dT,
    input  logic         job_reg_mode,
    input  logic         job_dt_mode,
    output logic         busy,
    output logic         cfg_done,
    output logic         res_valid,
    output logic [7:0]   res_G,
    output logic         res_err,
    output logic         cs,
    output logic         rd,
    output logic         wr,
    output logic [7:0]   addr,
    output logic [7:0]   wdata,
    input  logic [7:0]   rdata,
    output logic [3:0]   dbg_state
);

    typedef enum logic [3:0] {
        IDLE, CFG_WR, CFG_INIT, CFG_END, FLUSH, WR_MODE, WR_T, WR_DT,
        WR_START, POLL_WAIT, POLL_RD, G_GAP, RD_G, DONE
    } state_t;

    state_t        state, state_n;
    logic [4:0]    idx, idx_n;
    logic [7:0]    wcnt, wcnt_n;
    logic [15:0]   tmo;
    logic [191:0]  cfg_q;
    logic [7:0]    t_q, dtv_q;
    logic          reg_q, dt_q;
    logic          accept_cfg, accept_job;
    logic          cs_n, rd_n, wr_n, busy_n, cfg_done_n, res_valid_n, res_err_n;
    logic [7:0]    addr_n, wdata_n, res_g_n;

    assign dbg_state = state;

    // Next-state logic, then the bus/status values the next state presents.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        wcnt_n     = wcnt;
        res_g_n    = res_G;
        res_err_n  = res_err;
        accept_cfg = 1'b0;
        accept_job = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_req) begin
                    state_n    = CFG_WR;
                    idx_n      = 5'd0;
                    accept_cfg = 1'b1;
                end else if (job_req) begin
                    state_n    = FLUSH;
                    accept_job = 1'b1;
                end
            end
            CFG_WR: begin
                if (idx == 5'd23) state_n = CFG_INIT;
                else              idx_n   = idx + 5'd1;
            end
            CFG_INIT:  state_n = CFG_END;
            CFG_END:   state_n = IDLE;
            FLUSH:     state_n = WR_MODE;
            WR_MODE:   state_n = WR_T;
            WR_T:      state_n = dt_q ? WR_START : WR_DT;
            WR_DT:     state_n = WR_START;
            WR_START: begin
                state_n = POLL_WAIT;
                wcnt_n  = 8'd0;
            end
            POLL_WAIT: begin
                if (wcnt == 8'(POLL_GAP - 1)) state_n = POLL_RD;
                else                          wcnt_n  = wcnt + 8'd1;
            end
            POLL_RD: begin
                if (rdata[0]) begin
                    state_n = G_GAP;
                end else if (tmo >= 16'(TIMEOUT)) begin
                    state_n   = DONE;
                    res_g_n   = 8'h00;
                    res_err_n = 1'b1;
                end else begin
                    state_n = POLL_WAIT;
                    wcnt_n  = 8'd0;
                end
            end
            G_GAP:     state_n = RD_G;
            RD_G: begin
                state_n   = DONE;
                res_g_n   = rdata;
                res_err_n = 1'b0;
            end
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase

        cs_n    = 1'b0;
        rd_n    = 1'b0;
        wr_n    = 1'b0;
        addr_n  = 8'h00;
        wdata_n = 8'h00;
        case (state_n)
            CFG_WR: begin
                wr_n    = 1'b1;
                addr_n  = 8'h10 + {3'b000, idx_n};
                // On the accepting cycle cfg_q is not loaded yet.
                wdata_n = accept_cfg ? cfg_thr[7:0] : cfg_q[{idx_n, 3'b000} +: 8];
            end
            CFG_INIT: begin
                wr_n    = 1'b1;
                addr_n  = 8'h01;
                wdata_n = {4'b0000, 1'b1, dt_q, reg_q, 1'b0};
            end
            FLUSH, POLL_RD: begin
                rd_n   = 1'b1;
                addr_n = 8'h00;
            end
            WR_MODE: begin
                wr_n    = 1'b1;
                addr_n  = 8'h01;
                wdata_n = {5'b00000, dt_q, reg_q, 1'b0};
            end
            WR_T: begin
                wr_n    = 1'b1;
                addr_n  = 8'h02;
                wdata_n = t_q;
            end
            WR_DT: begin
                wr_n    = 1'b1;
                addr_n  = 8'h03;
                wdata_n = dtv_q;
            end
            WR_START: begin
                wr_n    = 1'b1;
                addr_n  = 8'h01;
                wdata_n = {5'b00000, dt_q, reg_q, 1'b1};
            end
            RD_G: begin
                rd_n   = 1'b1;
                addr_n = 8'h04;
            end
            default: ;
        endcase
        cs_n        = rd_n | wr_n;
        cfg_done_n  = (state_n == CFG_END);
        res_valid_n = (state_n == DONE);
        busy_n      = !(state_n inside {IDLE, CFG_END, DONE});
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 5'd0;
            wcnt      <= 8'd0;
            cs        <= 1'b0;
            rd        <= 1'b0;
            wr        <= 1'b0;
            addr      <= 8'h00;
            wdata     <= 8'h00;
            busy      <= 1'b0;
            cfg_done  <= 1'b0;
            res_valid <= 1'b0;
            res_G     <= 8'h00;
            res_err   <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            wcnt      <= wcnt_n;
            cs        <= cs_n;
            rd        <= rd_n;
            wr        <= wr_n;
            addr      <= addr_n;
            wdata     <= wdata_n;
            busy      <= busy_n;
            cfg_done  <= cfg_done_n;
            res_valid <= res_valid_n;
            res_G     <= res_g_n;
            res_err   <= res_err_n;
        end
    end

    // Timeout counter: zero during the START write, then counts up and saturates.
    always_ff @(posedge clk) begin
        if (rst)                     tmo <= 16'd0;
        else if (state_n == WR_START) tmo <= 16'd0;
        else if (tmo != 16'hFFFF)    tmo <= tmo + 16'd1;
    end

    // Request payload capture; mode bits persist and feed the INIT write.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= '0;
            t_q   <= 8'h00;
            dtv_q <= 8'h00;
            reg_q <= 1'b1;
            dt_q  <= 1'b1;
        end else begin
            if (accept_cfg) cfg_q <= cfg_thr;
            if (accept_job) begin
                t_q   <= job_T;
                dtv_q <= job_dT;
                reg_q <= job_reg_mode;
                dt_q  <= job_dt_mode;
            end
        end
    end

endmodule

// File: tb/tb_mmio_host_seq.sv
// tb_mmio_host_seq: directed bench for mmio_host_seq with a small register
// responder and a cycle-stamped expected bus trace.
module tb_mmio_host_seq;
  localparam int GAP = 4;
  localparam int TMO = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_req, job_req, job_reg_mode, job_dt_mode;
  logic [191:0] cfg_thr;
  logic [7:0]   job_T, job_dT;
  logic         busy, cfg_done, res_valid, res_err, cs, rd, wr;
  logic [7:0]   res_G, addr, wdata, rdata;
  logic [3:0]   dbg_state;

  mmio_host_seq #(.POLL_GAP(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_thr(cfg_thr),
    .job_req(job_req), .job_T(job_T), .job_dT(job_dT),
    .job_reg_mode(job_reg_mode), .job_dt_mode(job_dt_mode),
    .busy(busy), .cfg_done(cfg_done), .res_valid(res_valid),
    .res_G(res_G), .res_err(res_err), .cs(cs), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  int t0 = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- responder model ----------------
  logic       resp_on = 1'b0;
  logic [7:0] resp_g = 8'h00;
  logic       sticky;
  int         cd;

  assign rdata = (cs && rd) ? ((addr == 8'h00) ? {7'b0, sticky} :
                               (addr == 8'h04) ? resp_g : 8'h00) : 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      sticky <= 1'b0;
      cd     <= 0;
    end else begin
      if (cs && rd && addr == 8'h00) sticky <= 1'b0;
      if (cs && wr && addr == 8'h01 && wdata[0] && resp_on) cd <= 3;
      else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) sticky <= 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [25:0] exp_q[$];
  logic [25:0] mon_got, mon_exp;
  int res_cnt = 0;
  int cfg_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {cycle, rd, wr, addr, wdata}; write data is ignored for reads
  function automatic logic [25:0] pack(input int c, input logic r, input logic w,
                                       input logic [7:0] a, input logic [7:0] d);
    return {8'(c), r, w, a, (r ? 8'h00 : d)};
  endfunction

  function automatic void push(input int c, input logic r, input logic [7:0] a, input logic [7:0] d);
    exp_q.push_back(pack(c, r, !r, a, d));
  endfunction

  // bus monitor: every strobed cycle must match the head of the trace
  always @(negedge clk) begin
    if (res_valid) res_cnt++;
    if (cfg_done) cfg_cnt++;
    if (cs) begin
      check("one_strobe", 32'(rd ^ wr), 32'd1);
      mon_got = pack(cyc_cnt - t0, rd, wr, addr, wdata);
      if (exp_q.size() == 0) begin
        check("bus_extra", 32'(mon_got), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("bus_txn", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_cfg(input string tag, input logic [191:0] thr, input logic with_job,
                         input logic [7:0] exp_init);
    logic found;
    int   cc0;
    for (int k = 0; k < 24; k++) push(k + 1, 1'b0, 8'(8'h10 + k), thr[8*k +: 8]);
    push(25, 1'b0, 8'h01, exp_init);
    cc0 = cfg_cnt;
    @(posedge clk); #1;
    cfg_req = 1'b1; cfg_thr = thr; job_req = with_job;
    job_T = 8'h33; job_dT = 8'h44; job_reg_mode = 1'b0; job_dt_mode = 1'b0;
    t0 = cyc_cnt;
    @(posedge clk); #1;
    cfg_req = 1'b0; job_req = 1'b0;
    @(negedge clk);
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    found = 1'b0;
    while (!found && (cyc_cnt - t0) < 100) begin
      if (cfg_done) found = 1'b1;
      else begin
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
    check({tag, "_done_cycle"}, 32'(cyc_cnt - t0), 32'd26);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    #1;
    check({tag, "_done_pulses"}, 32'(cfg_cnt - cc0), 32'd1);
    check({tag, "_trace_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_job(input string tag, input logic [7:0] t, input logic [7:0] dtv,
                         input logic rm, input logic dm, input logic resp, input logic [7:0] g,
                         input int exp_done, input logic [7:0] exp_g, input logic exp_err,
                         input logic inject);
    int   base, p, rc0;
    logic found;
    base = dm ? 4 : 5;
    push(1, 1'b1, 8'h00, 8'h00);
    push(2, 1'b0, 8'h01, {5'b0, dm, rm, 1'b0});
    push(3, 1'b0, 8'h02, t);
    if (!dm) push(4, 1'b0, 8'h03, dtv);
    push(base, 1'b0, 8'h01, {5'b0, dm, rm, 1'b1});
    p = base + GAP + 1;
    if (resp) begin
      push(p, 1'b1, 8'h00, 8'h00);
      push(p + 2, 1'b1, 8'h04, 8'h00);
    end else begin
      while (p - base < TMO) begin
        push(p, 1'b1, 8'h00, 8'h00);
        p = p + GAP + 1;
      end
      push(p, 1'b1, 8'h00, 8'h00);
    end
    resp_on = resp; resp_g = g;
    rc0 = res_cnt;
    @(posedge clk); #1;
    job_req = 1'b1; job_T = t; job_dT = dtv; job_reg_mode = rm; job_dt_mode = dm;
    t0 = cyc_cnt;
    @(posedge clk); #1;
    job_req = 1'b0;
    @(negedge clk);
    check({tag, "_busy_c1"}, 32'(busy), 32'd1);
    found = 1'b0;
    while (!found && (cyc_cnt - t0) < 200) begin
      if (res_valid) found = 1'b1;
      else begin
        @(posedge clk); #1;
        cfg_req = inject && ((cyc_cnt - t0) == 3);
        job_req = cfg_req;
        if (cfg_req) job_T = 8'h55;
        @(negedge clk);
      end
    end
    check({tag, "_valid_seen"}, 32'(found), 32'd1);
    check({tag, "_valid_cycle"}, 32'(cyc_cnt - t0), 32'(exp_done));
    check({tag, "_res_G"}, 32'(res_G), 32'(exp_g));
    check({tag, "_res_err"}, 32'(res_err), 32'(exp_err));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    #1;
    check({tag, "_valid_pulses"}, 32'(res_cnt - rc0), 32'd1);
    @(negedge clk);
    check({tag, "_valid_1cyc"}, 32'(res_valid), 32'd0);
    check({tag, "_trace_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_rst_abort();
    int rc0;
    push(1, 1'b1, 8'h00, 8'h00);
    push(2, 1'b0, 8'h01, 8'h02);
    push(3, 1'b0, 8'h02, 8'h11);
    push(4, 1'b0, 8'h03, 8'h22);
    push(5, 1'b0, 8'h01, 8'h03);
    resp_on = 1'b0;
    rc0 = res_cnt;
    @(posedge clk); #1;
    job_req = 1'b1; job_T = 8'h11; job_dT = 8'h22; job_reg_mode = 1'b1; job_dt_mode = 1'b0;
    t0 = cyc_cnt;
    @(posedge clk); #1;
    job_req = 1'b0;
    while ((cyc_cnt - t0) < 7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_cs", 32'(cs), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (40) @(negedge clk);
    check("rst_no_valid", 32'(res_cnt - rc0), 32'd0);
    check("rst_trace_left", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  logic [191:0] thr1, thr2;

  initial begin
    rst = 1'b1; cfg_req = 1'b0; job_req = 1'b0; cfg_thr = '0;
    job_T = 8'h00; job_dT = 8'h00; job_reg_mode = 1'b0; job_dt_mode = 1'b0;
    for (int k = 0; k < 24; k++) begin
      thr1[8*k +: 8] = 8'(k + 1);
      thr2[8*k +: 8] = 8'(160 + 3 * k);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_bus", 32'({cs, rd, wr, addr, wdata}), 32'd0);
    check("reset_flags", 32'({busy, cfg_done, res_valid, res_err}), 32'd0);
    check("reset_res_G", 32'(res_G), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_cfg("cfg_first", thr1, 1'b0, 8'h0E);
    run_job("job_dt0", 8'h20, 8'hF6, 1'b1, 1'b0, 1'b1, 8'h5A, 13, 8'h5A, 1'b0, 1'b0);
    run_job("job_dt1", 8'h20, 8'hF6, 1'b1, 1'b1, 1'b1, 8'h5A, 12, 8'h5A, 1'b0, 1'b0);
    run_job("job_tmo", 8'h20, 8'hF6, 1'b1, 1'b0, 1'b0, 8'h5A, 41, 8'h00, 1'b1, 1'b0);
    run_cfg("cfg_race", thr2, 1'b1, 8'h0A);
    run_job("job_ignore", 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 8'hC3, 13, 8'hC3, 1'b0, 1'b1);
    run_rst_abort();
    run_cfg("cfg_after_rst", thr1, 1'b0, 8'h0E);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
